// File: rtl/au_op_sequencer.sv
// Command-level controller for the 16-bit arithmetic unit: loads operands over the
// 8-bit pin bus, runs the execute phase, reads the result back and returns it over valid/ready.
module au_op_sequencer #(
  parameter int CYC_ADDSUB = 17,
  parameter int TIMEOUT    = 255,
  parameter int RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_signed,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_flags,
  output logic        rsp_err,
  output logic [7:0]  au_ui,
  output logic [7:0]  au_ctrl,
  input  logic [7:0]  au_uo,
  input  logic [2:0]  au_flags,
  input  logic        au_err
);

  localparam logic [1:0] OP_LDR = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [1:0] REG_AL = 2'b00;
  localparam logic [1:0] REG_AH = 2'b01;
  localparam logic [1:0] REG_BL = 2'b10;
  localparam logic [1:0] REG_BH = 2'b11;

  localparam logic [7:0] EXEC_LAST = 8'(CYC_ADDSUB - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_LAT - 1);

  typedef enum logic [3:0] {
    IDLE,
    LD_AL,
    LD_AH,
    LD_BL,
    LD_BH,
    GAP,
    EXEC,
    RD_SEL_L,
    RD_L,
    RD_SEL_H,
    RD_H,
    RESP
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  op_reg;
  logic        signed_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [7:0]  cnt_reg, cnt_next;
  logic [7:0]  cnt_inc;
  logic [15:0] rsp_data_reg;
  logic [2:0]  rsp_flags_reg;
  logic        rsp_err_reg;

  logic        accept;
  logic        exec_done;
  logic        exec_timeout;
  logic        take_lo;
  logic        take_hi;
  logic        is_mul;
  logic        rd_bank;

  // Control byte layout on the unit's uio pins: {C, op, REG1, REG0, RW/UA, S, 0}
  function automatic logic [7:0] ctrl_word(input logic c, input logic [1:0] op,
                                           input logic [1:0] rsel, input logic rw,
                                           input logic s);
    return {c, op, rsel, rw, s, 1'b0};
  endfunction

  assign cnt_inc = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
  assign is_mul  = (op_reg == OP_MUL);
  // LDR returns A; every arithmetic op leaves its result in B
  assign rd_bank = (op_reg != OP_LDR);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    au_ui        = 8'h00;
    au_ctrl      = 8'h00;
    accept       = 1'b0;
    exec_done    = 1'b0;
    exec_timeout = 1'b0;
    take_lo      = 1'b0;
    take_hi      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = LD_AL;
        end
      end

      LD_AL: begin
        au_ctrl    = ctrl_word(signed_reg, OP_LDR, REG_AL, 1'b1, 1'b1);
        au_ui      = a_reg[7:0];
        state_next = LD_AH;
      end

      LD_AH: begin
        au_ctrl    = ctrl_word(signed_reg, OP_LDR, REG_AH, 1'b1, 1'b1);
        au_ui      = a_reg[15:8];
        state_next = LD_BL;
      end

      // MUL accumulates its product in B, so B starts from zero
      LD_BL: begin
        au_ctrl    = ctrl_word(signed_reg, OP_LDR, REG_BL, 1'b1, 1'b1);
        au_ui      = is_mul ? 8'h00 : b_reg[7:0];
        state_next = LD_BH;
      end

      LD_BH: begin
        au_ctrl    = ctrl_word(signed_reg, OP_LDR, REG_BH, 1'b1, 1'b1);
        au_ui      = is_mul ? 8'h00 : b_reg[15:8];
        state_next = GAP;
      end

      GAP: begin
        au_ctrl    = ctrl_word(signed_reg, op_reg, REG_AL, 1'b0, 1'b0);
        cnt_next   = 8'h00;
        state_next = (op_reg == OP_LDR) ? RD_SEL_L : EXEC;
      end

      EXEC: begin
        au_ctrl  = ctrl_word(signed_reg, op_reg, REG_AL, 1'b1, 1'b1);
        au_ui    = b_reg[7:0];
        cnt_next = cnt_inc;
        if (is_mul) begin
          if (au_flags[0]) begin
            exec_done = 1'b1;
          end else if (cnt_reg == TO_LAST) begin
            exec_timeout = 1'b1;
          end
        end else if (cnt_reg == EXEC_LAST) begin
          exec_done = 1'b1;
        end
        if (exec_done) begin
          cnt_next   = 8'h00;
          state_next = RD_SEL_L;
        end else if (exec_timeout) begin
          state_next = RESP;
        end
      end

      // Register select must stay put through the sampling cycle as well
      RD_SEL_L: begin
        au_ctrl  = ctrl_word(signed_reg, op_reg, {rd_bank, 1'b0}, 1'b0, 1'b0);
        cnt_next = cnt_inc;
        if (cnt_reg == RD_LAST) begin
          state_next = RD_L;
        end
      end

      RD_L: begin
        au_ctrl    = ctrl_word(signed_reg, op_reg, {rd_bank, 1'b0}, 1'b0, 1'b0);
        take_lo    = 1'b1;
        cnt_next   = 8'h00;
        state_next = RD_SEL_H;
      end

      RD_SEL_H: begin
        au_ctrl  = ctrl_word(signed_reg, op_reg, {rd_bank, 1'b1}, 1'b0, 1'b0);
        cnt_next = cnt_inc;
        if (cnt_reg == RD_LAST) begin
          state_next = RD_H;
        end
      end

      RD_H: begin
        au_ctrl    = ctrl_word(signed_reg, op_reg, {rd_bank, 1'b1}, 1'b0, 1'b0);
        take_hi    = 1'b1;
        state_next = RESP;
      end

      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg     <= IDLE;
      op_reg        <= OP_LDR;
      signed_reg    <= 1'b0;
      a_reg         <= 16'h0000;
      b_reg         <= 16'h0000;
      cnt_reg       <= 8'h00;
      rsp_data_reg  <= 16'h0000;
      rsp_flags_reg <= 3'b000;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;

      if (accept) begin
        op_reg        <= cmd_op;
        signed_reg    <= cmd_signed;
        a_reg         <= cmd_a;
        b_reg         <= cmd_b;
        rsp_data_reg  <= 16'h0000;
        rsp_flags_reg <= 3'b000;
        rsp_err_reg   <= 1'b0;
      end

      // Error is sticky for the op; frozen once the response is presented
      if (state_reg != IDLE && state_reg != RESP && au_err) begin
        rsp_err_reg <= 1'b1;
      end

      if (exec_done || exec_timeout) begin
        rsp_flags_reg <= au_flags;
      end

      if (exec_timeout) begin
        rsp_err_reg  <= 1'b1;
        rsp_data_reg <= 16'h0000;
      end

      if (take_lo) begin
        rsp_data_reg[7:0] <= au_uo;
      end

      if (take_hi) begin
        rsp_data_reg[15:8] <= au_uo;
      end
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_flags = rsp_flags_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_au_op_sequencer.sv
// Bench for au_op_sequencer: a behavioural arithmetic-unit model on the pin side,
// table-driven commands with a scoreboard queue, plus backpressure and mid-op reset sequences.
module tb_au_op_sequencer;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic        cmd_signed = 1'b0;
  logic [15:0] cmd_a = 16'h0000;
  logic [15:0] cmd_b = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic [7:0]  au_ui;
  logic [7:0]  au_ctrl;
  logic [7:0]  au_uo;
  logic [2:0]  au_flags;
  logic        au_err;

  always #5 clk = ~clk;

  au_op_sequencer dut (
    .clk       (clk),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_signed(cmd_signed),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .au_ui     (au_ui),
    .au_ctrl   (au_ctrl),
    .au_uo     (au_uo),
    .au_flags  (au_flags),
    .au_err    (au_err)
  );

  // Arithmetic unit model: byte loads, ADD/SUB done after 16 execute cycles,
  // MUL after 8, two-cycle registered read path.
  logic [15:0] ua = 16'h0000;
  logic [15:0] ub = 16'h0000;
  logic [1:0]  sel_d1 = 2'b00;
  logic [1:0]  sel_d2 = 2'b00;
  logic [3:0]  ucnt = 4'h0;
  logic        udone = 1'b0;
  logic        force_f0 = 1'b0;
  logic        inj_err = 1'b0;
  logic        un;

  always @(posedge clk) begin
    sel_d1 <= au_ctrl[4:3];
    sel_d2 <= sel_d1;
    if (au_ctrl[1] && au_ctrl[2] && au_ctrl[6:5] == 2'b00) begin
      case (au_ctrl[4:3])
        2'b00: ua[7:0]  <= au_ui;
        2'b01: ua[15:8] <= au_ui;
        2'b10: ub[7:0]  <= au_ui;
        default: ub[15:8] <= au_ui;
      endcase
    end
    if (!au_ctrl[1]) begin
      ucnt  <= 4'h0;
      udone <= 1'b0;
    end else if (au_ctrl[2] && au_ctrl[6:5] != 2'b00 && !udone) begin
      ucnt <= ucnt + 4'h1;
      if (au_ctrl[6:5] == 2'b11) begin
        if (ucnt == 4'd7) begin
          ub    <= ua * {8'h00, au_ui};
          udone <= 1'b1;
        end
      end else if (ucnt == 4'd15) begin
        ub    <= (au_ctrl[6:5] == 2'b01) ? ua + ub : ua - ub;
        udone <= 1'b1;
      end
    end
  end

  assign au_uo    = (sel_d2 == 2'b00) ? ua[7:0] : (sel_d2 == 2'b01) ? ua[15:8] :
                    (sel_d2 == 2'b10) ? ub[7:0] : ub[15:8];
  assign un       = au_ctrl[7] & ub[15];
  assign au_flags = {(ub != 16'h0000) & ~un, un, udone & ~force_f0};
  assign au_err   = inj_err;

  typedef struct {
    logic [1:0]  op;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic        f0;
    logic        inj;
    logic [15:0] data;
    logic [2:0]  flags;
    logic        err;
    int          exec_cyc;
    int          lat;
  } vec_t;

  vec_t vecs [10];
  vec_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exec_cnt = 0;
  logic run_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) exec_cnt <= 0;
    else if (au_ctrl[1] && au_ctrl[2] && au_ctrl[6:5] != 2'b00) exec_cnt <= exec_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk && !RST) chk("ready_valid_excl", {31'b0, cmd_ready & rsp_valid}, 32'd0);
  end

  task automatic run_cmd(input vec_t v, input int hold);
    int   n;
    int   t_acc;
    int   t_rsp;
    vec_t e;
    @(negedge clk);
    cmd_op     = v.op;
    cmd_signed = v.sgn;
    cmd_a      = v.a;
    cmd_b      = v.b;
    cmd_valid  = 1'b1;
    force_f0   = v.f0;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'b0, cmd_ready}, 32'd1);
    t_acc = cyc;
    sb_q.push_back(v);
    @(negedge clk);
    cmd_valid = 1'b0;
    inj_err   = v.inj;
    @(negedge clk);
    inj_err = 1'b0;
    n = 0;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrival", {31'b0, rsp_valid}, 32'd1);
    t_rsp = cyc;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      chk("hold_data", {16'b0, rsp_data}, {16'b0, e.data});
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    chk("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
    if (!e.f0) chk("rsp_flags", {29'b0, rsp_flags}, {29'b0, e.flags});
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
    chk("exec_cycles", exec_cnt, e.exec_cyc);
    chk("latency", t_rsp - t_acc, e.lat);
    $display("TXN op=%0d sgn=%0d a=%h b=%h data=%h flags=%b err=%0d exec=%0d lat=%0d",
             v.op, v.sgn, v.a, v.b, rsp_data, rsp_flags, rsp_err, exec_cnt, t_rsp - t_acc);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_resp", {31'b0, cmd_ready}, 32'd1);
    chk("valid_drop", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp;
    int   n;
    //           op     sgn   a         b         f0    inj   data      flags   err   exec lat
    vecs[0] = '{2'b01, 1'b0, 16'h0010, 16'h0005, 1'b0, 1'b0, 16'h0015, 3'b101, 1'b0, 17,  29};
    vecs[1] = '{2'b10, 1'b1, 16'h0003, 16'h0007, 1'b0, 1'b0, 16'hFFFC, 3'b011, 1'b0, 17,  29};
    vecs[2] = '{2'b11, 1'b0, 16'h0012, 16'h0034, 1'b0, 1'b0, 16'h03A8, 3'b101, 1'b0, 9,   21};
    vecs[3] = '{2'b11, 1'b0, 16'h0012, 16'h0034, 1'b1, 1'b0, 16'h0000, 3'b000, 1'b1, 255, 261};
    vecs[4] = '{2'b00, 1'b0, 16'hBEEF, 16'h1234, 1'b0, 1'b0, 16'hBEEF, 3'b000, 1'b0, 0,   12};
    vecs[5] = '{2'b01, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 3'b001, 1'b0, 17,  29};
    vecs[6] = '{2'b10, 1'b0, 16'h1000, 16'h0001, 1'b0, 1'b0, 16'h0FFF, 3'b101, 1'b0, 17,  29};
    vecs[7] = '{2'b01, 1'b1, 16'h7FF0, 16'h0020, 1'b0, 1'b0, 16'h8010, 3'b011, 1'b0, 17,  29};
    vecs[8] = '{2'b01, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0003, 3'b101, 1'b1, 17,  29};
    vecs[9] = '{2'b11, 1'b0, 16'h0101, 16'hAB03, 1'b0, 1'b0, 16'h0303, 3'b101, 1'b0, 9,   21};
    bp      = '{2'b01, 1'b0, 16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 3'b101, 1'b0, 17,  29};

    RST = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
    chk("rst_rsp_flags", {29'b0, rsp_flags}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_au_ui", {24'b0, au_ui}, 32'd0);
    chk("rst_au_ctrl", {24'b0, au_ctrl}, 32'd0);
    RST = 1'b0;
    run_chk = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i], 0);
    end

    run_cmd(bp, 10);

    // Reset in the middle of EXEC abandons the op without a response
    @(negedge clk);
    cmd_op     = 2'b01;
    cmd_signed = 1'b1;
    cmd_a      = 16'h0022;
    cmd_b      = 16'h0011;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (exec_cnt < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_exec", {31'b0, au_ctrl[2] & au_ctrl[1]}, 32'd1);
    RST = 1'b1;
    @(negedge clk);
    chk("midrst_au_ctrl", {24'b0, au_ctrl}, 32'd0);
    chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    RST = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("midrst_no_resp", n, 0);

    run_cmd(vecs[1], 0);
    run_cmd(vecs[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
